// File: rtl/gate_arb_pkg.sv
// Shared types and helpers for the gate request arbiter.
// Holds the FSM state encoding and round-robin index arithmetic.
package gate_arb_pkg;

    typedef enum logic [1:0] {
        S_HOLD,
        S_IDLE,
        S_GATE,
        S_GAP
    } state_e;

    localparam int HOLDOFF_DEF = 240;

    function automatic int next_idx(input int i, input int n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or
// after ptr, wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            valid,
    output logic [PW-1:0]   idx
);

    logic [PW-1:0] j;

    // Scan from the far end so the nearest index to ptr wins last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = PW'((int'(ptr) + k) % NREQ);
            if (req[j]) begin
                valid = 1'b1;
                idx   = j;
            end
        end
    end

endmodule

// File: rtl/gate_request_arbiter.sv
// Shares one programmable-length gate generator between NREQ
// edge-captured trigger sources, granted round-robin.
module gate_request_arbiter
    import gate_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int CNT_W   = 8,
    parameter int HOLDOFF = HOLDOFF_DEF,
    parameter int GAP     = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NREQ-1:0]  polarity_i,
    input  logic [NREQ-1:0]  pulse_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] width_i,
    input  logic             clr_ovf_i,
    output logic             gate_o,
    output logic [NREQ-1:0]  grant_o,
    output logic             busy_o,
    output logic             ready_o,
    output logic [NREQ-1:0]  overflow_o
);

    localparam int PW = $clog2(NREQ);
    localparam int HW = $clog2(HOLDOFF + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF - 1);
    localparam logic [CNT_W-1:0] GAP_LAST =
        CNT_W'((GAP > 0) ? GAP - 1 : 0);

    state_e           state, state_n;
    logic [HW-1:0]    hold_cnt, hold_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [PW-1:0]    ptr, ptr_n;
    logic [PW-1:0]    pick_idx;
    logic             pick_valid;
    logic             can_grant;
    logic             take;
    logic             gate_n;
    logic [NREQ-1:0]  norm, hist, rise;
    logic [NREQ-1:0]  pending, pend_n;
    logic [NREQ-1:0]  ovf_n, grant_n, take_mask;

    assign norm      = ~(pulse_i ^ polarity_i);
    assign rise      = norm & ~hist;
    assign can_grant = enable_i & pick_valid;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req   (pending),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_n   = state;
        hold_n    = hold_cnt;
        cnt_n     = cnt;
        ptr_n     = ptr;
        gate_n    = gate_o;
        grant_n   = grant_o;
        take      = 1'b0;
        take_mask = '0;

        unique case (state)
            S_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_n = S_IDLE;
                end else begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            S_IDLE: begin
                take = can_grant;
            end
            S_GATE: begin
                if (cnt == '0) begin
                    gate_n  = 1'b0;
                    grant_n = '0;
                    if (GAP == 0) begin
                        state_n = S_IDLE;
                        take    = can_grant;
                    end else begin
                        state_n = S_GAP;
                        cnt_n   = GAP_LAST;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            S_GAP: begin
                if (cnt == '0) begin
                    state_n = S_IDLE;
                    take    = can_grant;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = S_HOLD;
        endcase

        // A grant may start from IDLE or straight off a GATE/GAP exit.
        if (take) begin
            state_n   = S_GATE;
            gate_n    = 1'b1;
            grant_n   = NREQ'(1) << pick_idx;
            take_mask = grant_n;
            ptr_n     = PW'(next_idx(int'(pick_idx), NREQ));
            cnt_n     = (width_i == '0) ? '0 : width_i - 1'b1;
        end

        pend_n = (pending & ~take_mask)
               | ((state != S_HOLD) ? rise : '0);
        ovf_n  = (clr_ovf_i ? '0 : overflow_o)
               | (rise & pending);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= S_HOLD;
            hold_cnt   <= '0;
            cnt        <= '0;
            ptr        <= '0;
            hist       <= '0;
            pending    <= '0;
            overflow_o <= '0;
            gate_o     <= 1'b0;
            grant_o    <= '0;
            busy_o     <= 1'b0;
            ready_o    <= 1'b0;
        end else begin
            state      <= state_n;
            hold_cnt   <= hold_n;
            cnt        <= cnt_n;
            ptr        <= ptr_n;
            hist       <= norm;
            pending    <= pend_n;
            overflow_o <= ovf_n;
            gate_o     <= gate_n;
            grant_o    <= grant_n;
            busy_o     <= (state_n == S_GATE) ||
                          (state_n == S_GAP);
            ready_o    <= (state_n != S_HOLD);
        end
    end

endmodule

// File: tb/tb_gate_request_arbiter.sv
// Directed bench for gate_request_arbiter: holdoff, round-robin,
// polarity, overflow and mid-gate reset scenarios.
module tb_gate_request_arbiter;

    localparam int NREQ  = 4;
    localparam int CNT_W = 8;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic [NREQ-1:0]  polarity_i;
    logic [NREQ-1:0]  pulse_i;
    logic             enable_i;
    logic [CNT_W-1:0] width_i;
    logic             clr_ovf_i;
    logic             gate_o;
    logic [NREQ-1:0]  grant_o;
    logic             busy_o;
    logic             ready_o;
    logic [NREQ-1:0]  overflow_o;

    int n_chk  = 0;
    int n_fail = 0;

    gate_request_arbiter #(
        .NREQ    (NREQ),
        .CNT_W   (CNT_W),
        .HOLDOFF (240),
        .GAP     (1)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .polarity_i (polarity_i),
        .pulse_i    (pulse_i),
        .enable_i   (enable_i),
        .width_i    (width_i),
        .clr_ovf_i  (clr_ovf_i),
        .gate_o     (gate_o),
        .grant_o    (grant_o),
        .busy_o     (busy_o),
        .ready_o    (ready_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    initial begin
        logic gate_seen;
        logic prev_gate;
        int   rises;
        int   m;
        int   g;
        logic eg;
        logic [NREQ-1:0] eog;

        polarity_i = 4'b1111;
        pulse_i    = '0;
        enable_i   = 1'b1;
        width_i    = 8'd5;
        clr_ovf_i  = 1'b0;
        tick(2);

        check("rst_gate", gate_o, 0);
        check("rst_grant", grant_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ready", ready_o, 0);
        check("rst_ovf", overflow_o, 0);

        // Holdoff: level on req 0 from cycle 10 to 300.
        rst_i     = 1'b0;
        gate_seen = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            if (k == 10) pulse_i[0] = 1'b1;
            tick();
            if (gate_o) gate_seen = 1'b1;
            if (k == 239) check("ready_239", ready_o, 0);
            if (k == 240) check("ready_240", ready_o, 1);
        end
        check("hold_no_gate", gate_seen, 0);
        pulse_i = '0;
        tick(5);
        check("hold_idle_gate", gate_o, 0);
        check("hold_idle_busy", busy_o, 0);

        // Round-robin: all four at once, width 3, one gap clock.
        width_i = 8'd3;
        pulse_i = 4'b1111;
        tick();
        check("rr_lat", gate_o, 0);
        pulse_i = '0;
        for (int k = 1; k <= 18; k++) begin
            tick();
            m   = (k - 1) % 4;
            g   = (k - 1) / 4;
            eg  = (k <= 16) && (m < 3);
            eog = eg ? NREQ'(1 << g) : '0;
            check($sformatf("rr_gate_%0d", k), gate_o, eg);
            check($sformatf("rr_grant_%0d", k), grant_o, eog);
        end

        // Single one-clock trigger on req 2, width 5.
        width_i    = 8'd5;
        pulse_i[2] = 1'b1;
        tick();
        check("single_lat", gate_o, 0);
        pulse_i = '0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            eg = (k <= 5);
            check($sformatf("single_gate_%0d", k), gate_o, eg);
            check($sformatf("single_grant_%0d", k), grant_o,
                  eg ? 4'b0100 : 4'b0000);
            check($sformatf("single_busy_%0d", k), busy_o,
                  k <= 6);
        end

        // Negative logic on req 1, width 0 acts as 1.
        width_i       = 8'd0;
        polarity_i[1] = 1'b0;
        pulse_i[1]    = 1'b1;
        tick(3);
        check("neg_idle", gate_o, 0);
        pulse_i[1] = 1'b0;
        tick();
        check("neg_lat", gate_o, 0);
        pulse_i[1] = 1'b1;
        tick();
        check("neg_gate", gate_o, 1);
        check("neg_grant", grant_o, 4'b0010);
        tick();
        check("neg_gate_end", gate_o, 0);
        check("neg_grant_end", grant_o, 0);
        tick(3);
        check("neg_no_more", gate_o, 0);
        polarity_i[1] = 1'b1;
        pulse_i[1]    = 1'b0;
        tick(2);

        // Overflow: two edges on req 3 while grants are blocked.
        width_i    = 8'd5;
        enable_i   = 1'b0;
        pulse_i[3] = 1'b1;
        tick();
        check("ovf_first", overflow_o, 0);
        pulse_i = '0;
        tick();
        pulse_i[3] = 1'b1;
        tick();
        pulse_i = '0;
        check("ovf_set", overflow_o, 4'b1000);
        check("ovf_no_gate", gate_o, 0);
        tick(3);
        check("ovf_hold", gate_o, 0);
        enable_i  = 1'b1;
        rises     = 0;
        prev_gate = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (gate_o && !prev_gate) rises++;
            prev_gate = gate_o;
        end
        check("ovf_one_gate", rises, 1);
        check("ovf_sticky", overflow_o, 4'b1000);
        clr_ovf_i = 1'b1;
        tick();
        clr_ovf_i = 1'b0;
        check("ovf_clr", overflow_o, 0);

        // Reset at gate cycle 2 of 8 with req 1 still pending.
        width_i = 8'd8;
        pulse_i = 4'b0011;
        tick();
        pulse_i = '0;
        tick();
        check("mid_grant", grant_o, 4'b0001);
        tick();
        check("mid_gate2", gate_o, 1);
        rst_i = 1'b1;
        #1;
        check("mid_rst_gate", gate_o, 0);
        check("mid_rst_grant", grant_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_ready", ready_o, 0);
        tick();
        rst_i     = 1'b0;
        gate_seen = 1'b0;
        for (int k = 1; k <= 250; k++) begin
            tick();
            if (gate_o) gate_seen = 1'b1;
            if (k == 239) check("mid_ready_239", ready_o, 0);
            if (k == 240) check("mid_ready_240", ready_o, 1);
        end
        check("mid_pend_clr", gate_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
